// File: rtl/credit_arb2_if.sv
// credit_arb2_if: bundles the two requester address streams, the shared
// lookup port, the two response streams and the status outputs of
// credit_arb2. The slave modport is the arbiter's view; master is the
// environment's (requesters, lookup memory, response consumers).
interface credit_arb2_if #(
  parameter int DATA_W = 16
);
  logic [7:0]        in0_tdata;
  logic              in0_tvalid;
  logic              in0_tready;
  logic [7:0]        in1_tdata;
  logic              in1_tvalid;
  logic              in1_tready;
  logic [7:0]        rd_addr;
  logic              rd_read;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] out0_tdata;
  logic              out0_tvalid;
  logic              out0_tready;
  logic [DATA_W-1:0] out1_tdata;
  logic              out1_tvalid;
  logic              out1_tready;
  logic [15:0]       stat0;
  logic [15:0]       stat1;
  logic              err;

  modport slave (
    input  in0_tdata, in0_tvalid, in1_tdata, in1_tvalid,
    output in0_tready, in1_tready,
    output rd_addr, rd_read,
    input  rd_data, rd_valid,
    output out0_tdata, out0_tvalid, out1_tdata, out1_tvalid,
    input  out0_tready, out1_tready,
    output stat0, stat1, err
  );

  modport master (
    output in0_tdata, in0_tvalid, in1_tdata, in1_tvalid,
    input  in0_tready, in1_tready,
    input  rd_addr, rd_read,
    output rd_data, rd_valid,
    input  out0_tdata, out0_tvalid, out1_tdata, out1_tvalid,
    output out0_tready, out1_tready,
    input  stat0, stat1, err
  );
endinterface

// File: rtl/credit_arb2.sv
// credit_arb2: two-requester round-robin arbiter onto one shared lookup port.
// Each requester owns CREDITS slots of response buffering; a grant spends a
// credit, a pop from that requester's response FIFO returns it, so neither
// response FIFO nor the tag FIFO can overflow and rd_valid needs no
// back-pressure. A tag FIFO remembers which requester each in-flight lookup
// belongs to so in-order responses can be steered.
// Optional feature: define CREDIT_ARB2_STAT_EN to get 16-bit wrapping grant
// counters on stat0/stat1; otherwise they are tied to zero.
module credit_arb2 #(
  parameter int CREDITS = 8,
  parameter int DATA_W  = 16
) (
  input  logic         aclk,
  input  logic         reset_p,
  credit_arb2_if.slave bus
);
  localparam int CW  = $clog2(CREDITS) + 1;   // holds 0..CREDITS
  localparam int PW  = $clog2(CREDITS);       // response FIFO pointer
  localparam int TD  = 2 * CREDITS;           // tag FIFO depth
  localparam int TPW = $clog2(TD);            // tag FIFO pointer
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [1:0]             w_in_valid;
  logic [1:0][7:0]        w_in_data;
  logic [1:0]             w_out_ready;
  logic [1:0]             w_cred_nz;
  logic [1:0]             w_elig;
  logic [1:0]             w_gnt;
  logic [1:0]             w_pop;
  logic [1:0]             w_wr;
  logic [1:0]             w_out_valid;
  logic [1:0][DATA_W-1:0] w_out_data;
  logic [1:0][15:0]       w_stat;
  logic                   w_rd_read;

  logic                   r_last;     // requester granted most recently
  logic                   r_err;

  logic                   r_tag_mem [TD];
  logic [TPW-1:0]         r_tag_wp;
  logic [TPW-1:0]         r_tag_rp;
  logic [TPW:0]           r_tag_cnt;
  logic                   w_tag_empty;
  logic                   w_tag_pop;
  logic                   w_tag_head;

  assign w_in_valid  = {bus.in1_tvalid, bus.in0_tvalid};
  assign w_in_data   = {bus.in1_tdata,  bus.in0_tdata};
  assign w_out_ready = {bus.out1_tready, bus.out0_tready};

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    w_gnt = w_elig;
    if (w_elig == 2'b11) w_gnt = r_last ? 2'b01 : 2'b10;
  end

  assign w_rd_read = |w_gnt;

  // Pointer moves only when something is granted; reset favours requester 0.
  always_ff @(posedge aclk or posedge reset_p)
    if (reset_p)        r_last <= 1'b1;
    else if (w_rd_read) r_last <= w_gnt[1];

  // ---------------- tag FIFO: owner of each in-flight lookup ----------------
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_tag_pop   = bus.rd_valid & ~w_tag_empty;
  assign w_tag_head  = r_tag_mem[r_tag_rp];

  // Tag storage needs no reset; occupancy is tracked by r_tag_cnt.
  always_ff @(posedge aclk)
    if (w_rd_read) r_tag_mem[r_tag_wp] <= w_gnt[1];

  // Tag pointers/occupancy; push and pop in one cycle leave the count alone.
  always_ff @(posedge aclk or posedge reset_p)
    if (reset_p) begin
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_rd_read) r_tag_wp <= r_tag_wp + 1'b1;
      if (w_tag_pop) r_tag_rp <= r_tag_rp + 1'b1;
      if (w_rd_read & ~w_tag_pop)      r_tag_cnt <= r_tag_cnt + 1'b1;
      else if (w_tag_pop & ~w_rd_read) r_tag_cnt <= r_tag_cnt - 1'b1;
    end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge aclk or posedge reset_p)
    if (reset_p)                          r_err <= 1'b0;
    else if (bus.rd_valid & w_tag_empty)  r_err <= 1'b1;

  // ---------------- per-requester credit and response FIFO -----------------
  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [CW-1:0]     r_cred;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [DATA_W-1:0] r_mem [CREDITS];

    assign w_cred_nz[n]   = (r_cred != '0);
    assign w_elig[n]      = w_in_valid[n] & w_cred_nz[n] & ~reset_p;
    assign w_out_valid[n] = (r_cnt != '0);
    assign w_out_data[n]  = r_mem[r_rp];
    assign w_pop[n]       = w_out_valid[n] & w_out_ready[n];
    assign w_wr[n]        = w_tag_pop & (w_tag_head == 1'(n));

    // Credit spent on grant, returned on pop; both together cancel out.
    always_ff @(posedge aclk or posedge reset_p)
      if (reset_p)                     r_cred <= CRED_MAX;
      else if (w_gnt[n] & ~w_pop[n])   r_cred <= r_cred - 1'b1;
      else if (w_pop[n] & ~w_gnt[n])   r_cred <= r_cred + 1'b1;

    // Response data storage; occupancy tracked separately.
    always_ff @(posedge aclk)
      if (w_wr[n]) r_mem[r_wp] <= bus.rd_data;

    // FWFT FIFO pointers and occupancy.
    always_ff @(posedge aclk or posedge reset_p)
      if (reset_p) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_wr[n])  r_wp <= r_wp + 1'b1;
        if (w_pop[n]) r_rp <= r_rp + 1'b1;
        if (w_wr[n] & ~w_pop[n])      r_cnt <= r_cnt + 1'b1;
        else if (w_pop[n] & ~w_wr[n]) r_cnt <= r_cnt - 1'b1;
      end

`ifdef CREDIT_ARB2_STAT_EN
    logic [15:0] r_stat;
    // Wrapping count of grants to this requester.
    always_ff @(posedge aclk or posedge reset_p)
      if (reset_p)       r_stat <= '0;
      else if (w_gnt[n]) r_stat <= r_stat + 1'b1;
    assign w_stat[n] = r_stat;
`else
    assign w_stat[n] = '0;
`endif
  end

  // ---------------- outputs ----------------
  assign bus.in0_tready  = w_gnt[0];
  assign bus.in1_tready  = w_gnt[1];
  assign bus.rd_read     = w_rd_read;
  assign bus.rd_addr     = w_gnt[0] ? w_in_data[0] :
                           w_gnt[1] ? w_in_data[1] : 8'h00;
  assign bus.out0_tvalid = w_out_valid[0];
  assign bus.out0_tdata  = w_out_data[0];
  assign bus.out1_tvalid = w_out_valid[1];
  assign bus.out1_tdata  = w_out_data[1];
  assign bus.stat0       = w_stat[0];
  assign bus.stat1       = w_stat[1];
  assign bus.err         = r_err;
endmodule

// File: tb/tb_credit_arb2.sv
// tb_credit_arb2: directed scenarios plus a random phase for credit_arb2.
// The reference tracks, per requester, how many grants are not yet popped
// (credit = CREDITS - that), a queue of outstanding lookups with due
// cycles (acting as the lookup memory), and queues of expected responses.
module tb_credit_arb2;
  localparam int CREDITS = 8;
  localparam int DATA_W  = 16;

  logic aclk = 1'b0;
  logic reset_p;

  credit_arb2_if #(.DATA_W(DATA_W)) bus ();
  credit_arb2 #(.CREDITS(CREDITS), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .reset_p(reset_p), .bus(bus));

  always #5 aclk = ~aclk;

  typedef struct {
    bit                id;
    logic [DATA_W-1:0] d;
    int unsigned       due;
  } pend_t;

  int          nchk = 0;
  int          nfail = 0;
  int unsigned cyc = 0;
  bit   [1:0]  v;
  bit   [1:0]  rdy;
  logic [7:0]  a [2];
  bit          spur;
  int          lat_lo, lat_hi;
  int          infl [2];
  int          gcnt [2];
  int          stat_m [2];
  bit          last;
  bit          err_m;
  pend_t       pend [$];
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check at negedge, advance the reference at posedge+1.
  task automatic step();
    bit [1:0]    el, g;
    bit          rv;
    pend_t       p;
    int unsigned due;
    a[0] = 8'($urandom);
    a[1] = 8'($urandom);
    bus.in0_tvalid  = v[0];
    bus.in0_tdata   = a[0];
    bus.in1_tvalid  = v[1];
    bus.in1_tdata   = a[1];
    bus.out0_tready = rdy[0];
    bus.out1_tready = rdy[1];
    rv = spur || (pend.size() != 0 && pend[0].due <= cyc);
    bus.rd_valid = rv;
    bus.rd_data  = (pend.size() != 0 && !spur) ? pend[0].d : DATA_W'($urandom);
    @(negedge aclk);
    for (int n = 0; n < 2; n++) el[n] = v[n] && (infl[n] < CREDITS);
    g = (el == 2'b11) ? (last ? 2'b01 : 2'b10) : el;
    chk("in0_tready", 32'(bus.in0_tready), 32'(g[0]));
    chk("in1_tready", 32'(bus.in1_tready), 32'(g[1]));
    chk("rd_read", 32'(bus.rd_read), 32'(|g));
    chk("rd_addr", 32'(bus.rd_addr), g[0] ? 32'(a[0]) : (g[1] ? 32'(a[1]) : 32'd0));
    chk("out0_tvalid", 32'(bus.out0_tvalid), 32'(q0.size() != 0));
    if (q0.size() != 0) chk("out0_tdata", 32'(bus.out0_tdata), 32'(q0[0]));
    chk("out1_tvalid", 32'(bus.out1_tvalid), 32'(q1.size() != 0));
    if (q1.size() != 0) chk("out1_tdata", 32'(bus.out1_tdata), 32'(q1[0]));
    chk("err", 32'(bus.err), 32'(err_m));
`ifdef CREDIT_ARB2_STAT_EN
    chk("stat0", 32'(bus.stat0), 32'(stat_m[0]));
    chk("stat1", 32'(bus.stat1), 32'(stat_m[1]));
`else
    chk("stat0", 32'(bus.stat0), 32'd0);
    chk("stat1", 32'(bus.stat1), 32'd0);
`endif
    @(posedge aclk);
    #1;
    if (q0.size() != 0 && rdy[0]) begin void'(q0.pop_front()); infl[0]--; end
    if (q1.size() != 0 && rdy[1]) begin void'(q1.pop_front()); infl[1]--; end
    if (rv) begin
      if (pend.size() == 0) err_m = 1'b1;
      else begin
        p = pend.pop_front();
        if (p.id) q1.push_back(p.d); else q0.push_back(p.d);
      end
    end
    for (int n = 0; n < 2; n++)
      if (g[n]) begin
        infl[n]++;
        gcnt[n]++;
        stat_m[n] = (stat_m[n] + 1) % 65536;
        last = 1'(n);
        due = cyc + 32'($urandom_range(lat_hi, lat_lo));
        if (pend.size() != 0 && pend[$].due > due) due = pend[$].due;
        p.id = 1'(n);
        p.d  = DATA_W'($urandom);
        p.due = due;
        pend.push_back(p);
      end
    cyc++;
  endtask

  // Assert reset mid-cycle, check outputs are quiet, then release.
  task automatic do_reset();
    bus.rd_valid   = 1'b0;
    bus.in0_tvalid = 1'b1;
    bus.in1_tvalid = 1'b1;
    reset_p = 1'b1;
    #1;
    chk("rst_in0_tready", 32'(bus.in0_tready), 32'd0);
    chk("rst_in1_tready", 32'(bus.in1_tready), 32'd0);
    chk("rst_rd_read", 32'(bus.rd_read), 32'd0);
    chk("rst_out0_tvalid", 32'(bus.out0_tvalid), 32'd0);
    chk("rst_out1_tvalid", 32'(bus.out1_tvalid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_stat0", 32'(bus.stat0), 32'd0);
    chk("rst_stat1", 32'(bus.stat1), 32'd0);
    @(posedge aclk);
    #1;
    chk("rst_hold_in0_tready", 32'(bus.in0_tready), 32'd0);
    reset_p = 1'b0;
    infl = '{0, 0};
    stat_m = '{0, 0};
    last = 1'b1;
    err_m = 1'b0;
    spur = 1'b0;
    pend.delete();
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int n;
    reset_p = 1'b1;
    bus.in0_tvalid = 1'b0; bus.in0_tdata = '0;
    bus.in1_tvalid = 1'b0; bus.in1_tdata = '0;
    bus.rd_valid = 1'b0;   bus.rd_data = '0;
    bus.out0_tready = 1'b0; bus.out1_tready = 1'b0;
    v = 2'b00; rdy = 2'b00; spur = 1'b0;
    lat_lo = 3; lat_hi = 3;
    gcnt = '{0, 0};
    @(posedge aclk);
    #1;
    do_reset();

    // Both streaming, outputs ready, latency 3: strict alternation.
    v = 2'b11; rdy = 2'b11;
    repeat (40) step();
    chk("alt_grants0", 32'(gcnt[0]), 32'd20);
    chk("alt_grants1", 32'(gcnt[1]), 32'd20);
    v = 2'b00;
    repeat (12) step();

    // out0 stalled: requester 0 exhausts its credits, requester 1 keeps going.
    gcnt = '{0, 0};
    lat_lo = 2; lat_hi = 2;
    v = 2'b11; rdy = 2'b10;
    repeat (20) step();
    chk("stall_grants0", 32'(gcnt[0]), 32'd8);
    chk("stall_grants1", 32'(gcnt[1]), 32'd12);

    // One pop frees one credit; it is spent again on the next grant.
    gcnt = '{0, 0};
    v = 2'b01; rdy = 2'b11;
    step();
    rdy = 2'b10;
    repeat (4) step();
    chk("refill_grants0", 32'(gcnt[0]), 32'd1);
    v = 2'b00; rdy = 2'b11;
    repeat (16) step();

    // Stray response with nothing outstanding: dropped, error is sticky.
    repeat (10) step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (5) step();
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Random traffic, back-pressure and latency jitter.
    lat_lo = 1; lat_hi = 6;
    repeat (800) begin
      v   = 2'($urandom);
      rdy = 2'($urandom);
      step();
    end
    v = 2'b00; rdy = 2'b11;
    repeat (30) step();

    // Reset with 5 lookups outstanding.
    lat_lo = 20; lat_hi = 20;
    v = 2'b01;
    repeat (5) step();
    chk("pre_rst_outstanding", 32'(gcnt[0] > 0), 32'd1);
    do_reset();
    gcnt = '{0, 0};
    lat_lo = 2; lat_hi = 2;
    v = 2'b01; rdy = 2'b00;
    repeat (10) step();
    chk("post_rst_credits", 32'(gcnt[0]), 32'd8);

    // Long run on requester 1 alone: stat1 wraps.
    gcnt = '{0, 0};
    v = 2'b10; rdy = 2'b11;
    n = 0;
    while (gcnt[1] < 70000 && n < 75000) begin
      step();
      n++;
    end
    chk("grants1_70000", 32'(gcnt[1]), 32'd70000);
    @(negedge aclk);
`ifdef CREDIT_ARB2_STAT_EN
    chk("stat1_wrap", 32'(bus.stat1), 32'd4464);
`else
    chk("stat1_off", 32'(bus.stat1), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
